// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle control sequencer.
//   state_t           - sequencer states
//   SRCB_* / RES_* / ALU_* - datapath select and ALU operation encodings
//   OP_* / CMD_*      - instruction field values decoded by the controller
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      UNKNOWN  = 4'd10
   } state_t;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ResultSrc encodings
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // ALUControl encodings
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Op field classes
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Data-processing cmd field values
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the data-processing fields onto ALU operation and
// flag-write requests. Only active while the sequencer is in an execute or
// ALU writeback state (ALUOp=1); otherwise it requests a plain ADD with no
// flag or write suppression.
//   Funct      in  6  I, cmd[3:0], S
//   ALUOp      in  1  data-processing instruction in progress
//   ALUControl out 2  ALU operation
//   FlagW      out 2  [1] NZ write, [0] CV write
//   NoWrite    out 1  compare: suppress result write
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [5:0] Funct,
   input  logic       ALUOp,
   output logic [1:0] ALUControl,
   output logic [1:0] FlagW,
   output logic       NoWrite
);

   logic [3:0] cmd_s;
   logic       arith_s;

   assign cmd_s = Funct[4:1];

   // Decode cmd into ALU operation and flag-write enables.
   always_comb begin
      ALUControl = ALU_ADD;
      FlagW      = 2'b00;
      NoWrite    = 1'b0;
      arith_s    = 1'b0;
      if (ALUOp) begin
         case (cmd_s)
            CMD_ADD: begin
               ALUControl = ALU_ADD;
               arith_s    = 1'b1;
               FlagW      = {Funct[0], Funct[0] & arith_s};
            end
            CMD_SUB: begin
               ALUControl = ALU_SUB;
               arith_s    = 1'b1;
               FlagW      = {Funct[0], Funct[0] & arith_s};
            end
            CMD_AND: begin
               ALUControl = ALU_AND;
               FlagW      = {Funct[0], 1'b0};
            end
            CMD_ORR: begin
               ALUControl = ALU_ORR;
               FlagW      = {Funct[0], 1'b0};
            end
            CMD_CMP: begin
               ALUControl = ALU_SUB;
               arith_s    = 1'b1;
               NoWrite    = 1'b1;
               FlagW      = {Funct[0], Funct[0] & arith_s};
            end
            // Unsupported commands: harmless ADD, no flag update.
            default: begin
               ALUControl = ALU_ADD;
               FlagW      = 2'b00;
            end
         endcase
      end else begin
         ALUControl = ALU_ADD;
         FlagW      = 2'b00;
      end
   end

endmodule

// File: rtl/main_fsm.sv
// main_fsm: multicycle control sequencer. Steps each instruction through
// fetch/decode/execute/writeback and drives Moore datapath selects plus the
// unconditioned write requests consumed by the downstream condition logic.
//   clk, reset (async, active-low)
//   Op, Funct, Rd        instruction fields, valid from DECODE onwards
//   IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc  datapath selects
//   ALUControl, FlagW, NoWrite                            ALU decode
//   PCS, RegW, MemW                                       write requests
module main_fsm
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic [1:0] FlagW,
   output logic       PCS,
   output logic       RegW,
   output logic       MemW,
   output logic       NoWrite
);

   state_t state_r;
   state_t next_state_s;
   logic   branch_s;
   logic   aluop_s;
   logic   regw_s;

   // State register; reset forces FETCH immediately so the FETCH encoding
   // is visible for the whole time reset is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = FETCH;
      case (state_r)
         FETCH:  next_state_s = DECODE;
         DECODE: begin
            case (Op)
               OP_MEM:  next_state_s = MEMADR;
               OP_DP:   next_state_s = Funct[5] ? EXECUTEI : EXECUTER;
               OP_BR:   next_state_s = BRANCH;
               default: next_state_s = UNKNOWN;
            endcase
         end
         MEMADR:   next_state_s = Funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:  next_state_s = MEMWB;
         EXECUTER: next_state_s = ALUWB;
         EXECUTEI: next_state_s = ALUWB;
         default:  next_state_s = FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .Funct      (Funct),
      .ALUOp      (aluop_s),
      .ALUControl (ALUControl),
      .FlagW      (FlagW),
      .NoWrite    (NoWrite)
   );

   // Moore output decode; RegW in ALUWB depends on the compare suppression.
   always_comb begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      MemW      = 1'b0;
      regw_s    = 1'b0;
      branch_s  = 1'b0;
      aluop_s   = 1'b0;
      case (state_r)
         FETCH: begin
            IRWrite   = 1'b1;
            NextPC    = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
         end
         MEMADR:   ALUSrcB = SRCB_IMM;
         MEMREAD:  AdrSrc  = 1'b1;
         MEMWB: begin
            ResultSrc = RES_RDATA;
            regw_s    = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         EXECUTER: aluop_s = 1'b1;
         EXECUTEI: begin
            ALUSrcB = SRCB_IMM;
            aluop_s = 1'b1;
         end
         ALUWB: begin
            aluop_s = 1'b1;
            regw_s  = ~NoWrite;
         end
         BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURES;
            branch_s  = 1'b1;
         end
         default: begin
            // UNKNOWN: no selects, no writes.
            regw_s = 1'b0;
         end
      endcase
   end

   // A register write targeting R15 is a PC write.
   assign RegW = regw_s;
   assign PCS  = branch_s | (regw_s & (Rd == 4'hF));

endmodule
